feature_tx_serializer: RTL and testbench

- Transmit-side consumer of the CCA bounding-box records. Accepts completed blob feature words {minx, maxx, miny, maxy} as produced by the feature accumulator path.
- Buffers the records and serializes each one as a framed byte packet over a valid/ready byte stream toward the host-link UART/SPI bridge.
- On each frame boundary it emits an end-of-frame packet carrying the number of blobs sent in that frame.

---
 rtl/feature_tx_pkg.sv | 17 +
 rtl/feature_fifo.sv | 62 ++++++
 rtl/feature_tx_serializer.sv | 259 +++++++++++++++++++++++++
 tb/tb_feature_tx_serializer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_tx_pkg.sv
// Shared constants and FSM encoding for the blob feature transmit serializer.
// FEATURE_TX_CHECKSUM_EN adds a trailing XOR byte to every packet (CKSUM state).
package feature_tx_pkg;

    localparam logic [7:0] HDR_REC = 8'hA5;
    localparam logic [7:0] HDR_EOF = 8'h5A;
    localparam int         REC_LEN = 8;
    localparam int         EOF_LEN = 2;
    localparam int         IDX_BIT = 3;

`ifdef FEATURE_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAY, EOF_HDR, EOF_CNT, CKSUM} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAY, EOF_HDR, EOF_CNT} tx_state_t;
`endif

endpackage

// File: rtl/feature_fifo.sv
// Single-clock record FIFO; read data is registered and valid the cycle after a pop.
// A push while full is refused even if a pop happens in the same cycle.
module feature_fifo #(
    parameter int data_bit   = 38,
    parameter int fifo_depth = 16,
    parameter int fifo_abit  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [data_bit-1:0] wr_data,
    input  logic                rd_en,
    output logic [data_bit-1:0] rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty
);

    logic [data_bit-1:0] mem [fifo_depth];
    logic [fifo_abit:0]  wr_ptr_reg;
    logic [fifo_abit:0]  rd_ptr_reg;
    logic [data_bit-1:0] rd_data_reg;
    logic                rd_valid_reg;
    logic                push;
    logic                pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[fifo_abit] != rd_ptr_reg[fifo_abit]) &&
                   (wr_ptr_reg[fifo_abit-1:0] == rd_ptr_reg[fifo_abit-1:0]);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[fifo_abit-1:0]] <= wr_data;
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg[fifo_abit-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            rd_valid_reg <= pop;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/feature_tx_serializer.sv
// Buffers blob bounding-box records and streams them as framed byte packets,
// plus an end-of-frame packet with the blob count. Option: FEATURE_TX_CHECKSUM_EN.
module feature_tx_serializer
    import feature_tx_pkg::*;
#(
    parameter int x_bit      = 9,
    parameter int y_bit      = 9,
    parameter int data_bit   = 38,
    parameter int fifo_depth = 16,
    parameter int fifo_abit  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rec_valid,
    input  logic [data_bit-1:0] rec_data,
    input  logic                frame_end,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                overflow,
    output logic                busy
);

    localparam int GAP_BIT = data_bit - x_bit - 2*y_bit;

    tx_state_t           state_reg, state_next;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic                tx_valid_reg, tx_valid_next;
    logic [IDX_BIT-1:0]  idx_reg, idx_next;
    logic [63:0]         shift_reg, shift_next;
    logic [15:0]         blob_cnt_reg;
    logic [15:0]         eof_cnt_reg;
    logic [15:0]         blob_sum;
    logic                eof_pending_reg, eof_pending_next;
    logic                overflow_reg;
    logic                eof_clear;
`ifdef FEATURE_TX_CHECKSUM_EN
    logic [7:0]          cks_reg, cks_next;
`endif

    logic [x_bit-1:0]    rec_minx, rec_maxx;
    logic [y_bit-1:0]    rec_miny, rec_maxy;
    logic                box_ok, rec_take, rec_push, rec_drop;
    logic                fe_take, fe_drop;

    logic                fifo_pop, fifo_full, fifo_empty, fifo_rd_valid;
    logic [data_bit-1:0] fifo_rd_data;
    logic [15:0]         field [4];
    logic [63:0]         rd_payload;
    logic [63:0]         cur_pay;

    assign rec_minx = rec_data[data_bit-1 -: x_bit];
    assign rec_maxx = rec_data[2*y_bit +: x_bit];
    assign rec_miny = rec_data[2*y_bit-1 -: y_bit];
    assign rec_maxy = rec_data[y_bit-1:0];

    // Inverted boxes are the accumulator's cleared value and are silently discarded.
    assign box_ok   = (rec_minx <= rec_maxx) && (rec_miny <= rec_maxy);
    assign rec_take = rec_valid && box_ok;
    assign rec_push = rec_take && !fifo_full;
    assign rec_drop = rec_take && fifo_full;
    assign fe_take  = frame_end && !eof_pending_reg;
    assign fe_drop  = frame_end && eof_pending_reg;

    feature_fifo #(
        .data_bit   (data_bit),
        .fifo_depth (fifo_depth),
        .fifo_abit  (fifo_abit)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rec_push),
        .wr_data  (rec_data),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .rd_valid (fifo_rd_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign field[0] = 16'(fifo_rd_data[data_bit-1 -: x_bit]);
    assign field[1] = 16'(fifo_rd_data[2*y_bit +: x_bit]);
    assign field[2] = 16'(fifo_rd_data[2*y_bit-1 -: y_bit]);
    assign field[3] = 16'(fifo_rd_data[y_bit-1:0]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
        assign rd_payload[63-16*gi -: 16] = field[gi];
    end

    if (GAP_BIT > x_bit) begin : g_gap
        logic unused_gap;
        assign unused_gap = ^{rec_data[data_bit-x_bit-1 : 2*y_bit+x_bit],
                              fifo_rd_data[data_bit-x_bit-1 : 2*y_bit+x_bit]};
    end

    // The popped word lands one cycle after the pop, i.e. while HDR is shown.
    assign cur_pay = fifo_rd_valid ? rd_payload : shift_reg;

    // A record accepted together with frame_end belongs to the ending frame.
    assign blob_sum = (rec_push && (blob_cnt_reg != 16'hFFFF)) ? blob_cnt_reg + 16'd1
                                                               : blob_cnt_reg;

    always_comb begin
        eof_pending_next = eof_pending_reg;
        if (fe_take) begin
            eof_pending_next = 1'b1;
        end else if (eof_clear) begin
            eof_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blob_cnt_reg    <= '0;
            eof_cnt_reg     <= '0;
            eof_pending_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (fe_take) begin
                eof_cnt_reg  <= blob_sum;
                blob_cnt_reg <= '0;
            end else begin
                blob_cnt_reg <= blob_sum;
            end
            eof_pending_reg <= eof_pending_next;
            if (rec_drop || fe_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            idx_reg      <= '0;
            shift_reg    <= '0;
`ifdef FEATURE_TX_CHECKSUM_EN
            cks_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
`ifdef FEATURE_TX_CHECKSUM_EN
            cks_reg      <= cks_next;
`endif
        end
    end

    // tx_data/tx_valid are registered: each state computes the byte shown next.
    always_comb begin
        state_next    = state_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        idx_next      = idx_reg;
        shift_next    = shift_reg;
        fifo_pop      = 1'b0;
        eof_clear     = 1'b0;
`ifdef FEATURE_TX_CHECKSUM_EN
        cks_next      = cks_reg;
`endif
        if (fifo_rd_valid) begin
            shift_next = rd_payload;
        end

        case (state_reg)
            IDLE: begin
                tx_valid_next = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    state_next    = HDR;
                    tx_valid_next = 1'b1;
                    tx_data_next  = HDR_REC;
                end else if (eof_pending_reg) begin
                    state_next    = EOF_HDR;
                    tx_valid_next = 1'b1;
                    tx_data_next  = HDR_EOF;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    state_next   = PAY;
                    idx_next     = '0;
                    tx_data_next = cur_pay[63:56];
                    shift_next   = {cur_pay[55:0], 8'h00};
`ifdef FEATURE_TX_CHECKSUM_EN
                    cks_next     = '0;
`endif
                end
            end
            PAY: begin
                if (tx_ready) begin
`ifdef FEATURE_TX_CHECKSUM_EN
                    cks_next = cks_reg ^ tx_data_reg;
`endif
                    if (idx_reg == IDX_BIT'(REC_LEN-1)) begin
`ifdef FEATURE_TX_CHECKSUM_EN
                        state_next    = CKSUM;
                        tx_data_next  = cks_reg ^ tx_data_reg;
`else
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
`endif
                    end else begin
                        idx_next     = idx_reg + 1'b1;
                        tx_data_next = shift_reg[63:56];
                        shift_next   = {shift_reg[55:0], 8'h00};
                    end
                end
            end
            EOF_HDR: begin
                if (tx_ready) begin
                    state_next   = EOF_CNT;
                    idx_next     = '0;
                    tx_data_next = eof_cnt_reg[15:8];
                end
            end
            EOF_CNT: begin
                if (tx_ready) begin
                    if (idx_reg == IDX_BIT'(EOF_LEN-1)) begin
                        eof_clear = 1'b1;
`ifdef FEATURE_TX_CHECKSUM_EN
                        state_next    = CKSUM;
                        tx_data_next  = eof_cnt_reg[15:8] ^ eof_cnt_reg[7:0];
`else
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
`endif
                    end else begin
                        idx_next     = idx_reg + 1'b1;
                        tx_data_next = eof_cnt_reg[7:0];
                    end
                end
            end
`ifdef FEATURE_TX_CHECKSUM_EN
            CKSUM: begin
                if (tx_ready) begin
                    state_next    = IDLE;
                    tx_valid_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
            end
        endcase
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty || eof_pending_reg;

endmodule

// File: tb/tb_feature_tx_serializer.sv
// Directed bench for feature_tx_serializer; expectations follow FEATURE_TX_CHECKSUM_EN.
// Each accepted stream byte is logged on its own line.
module tb_feature_tx_serializer;

`ifdef FEATURE_TX_CHECKSUM_EN
    localparam int REC_PKT = 10;
    localparam int EOF_PKT = 4;
`else
    localparam int REC_PKT = 9;
    localparam int EOF_PKT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_valid = 1'b0;
    logic [37:0] rec_data = '0;
    logic        frame_end = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    feature_tx_serializer #(
        .x_bit      (9),
        .y_bit      (9),
        .data_bit   (38),
        .fifo_depth (16),
        .fifo_abit  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rec_valid (rec_valid),
        .rec_data  (rec_data),
        .frame_end (frame_end),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bytes are captured mid-cycle; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            $display("tx byte %02h", tx_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rec(input logic [8:0] mnx, input logic [8:0] mxx,
                            input logic [8:0] mny, input logic [8:0] mxy, input logic fe);
        rec_valid = 1'b1;
        rec_data  = {mnx, 2'b00, mxx, mny, mxy};
        frame_end = fe;
        step();
        rec_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rec_valid = 1'b0;
        frame_end = 1'b0;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic exp_rec(input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d);
        logic [63:0] w;
`ifdef FEATURE_TX_CHECKSUM_EN
        logic [7:0] x;
`endif
        w = {7'd0, a, 7'd0, b, 7'd0, c, 7'd0, d};
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
`ifdef FEATURE_TX_CHECKSUM_EN
        x = 8'h00;
        for (int i = 7; i >= 0; i--) x = x ^ w[8*i +: 8];
        exp_q.push_back(x);
`endif
    endtask

    task automatic exp_eof(input logic [15:0] n);
        exp_q.push_back(8'h5A);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
`ifdef FEATURE_TX_CHECKSUM_EN
        exp_q.push_back(n[15:8] ^ n[7:0]);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", tx_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        tx_ready = 1'b1;
        send_rec(9'd3, 9'd10, 9'd5, 9'd300, 1'b0);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got valid %b exp 0", tx_valid); end
        step();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_first got valid %b data %02h exp 1 a5", tx_valid, tx_data); end
        repeat (REC_PKT) step();
        checks++; if (got_q.size() != REC_PKT) begin
            errors++; $display("FAIL single_burst got %0d bytes exp %0d", got_q.size(), REC_PKT); end
        exp_q = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h01, 8'h2C};
`ifdef FEATURE_TX_CHECKSUM_EN
        exp_q.push_back(8'h21);
`endif
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        pulse_fe();
        wait_bytes(EOF_PKT, 50);
        exp_q = '{8'h5A, 8'h00, 8'h01};
`ifdef FEATURE_TX_CHECKSUM_EN
        exp_q.push_back(8'h01);
`endif
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_eof_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_eof%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_empty_box();
        do_reset();
        tx_ready = 1'b1;
        send_rec(9'h1FF, 9'h000, 9'h1FF, 9'h000, 1'b0);
        repeat (20) step();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL empty_out got %0d bytes exp 0", got_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %b exp 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL empty_ovf got %b exp 0", overflow); end
        pulse_fe();
        wait_bytes(EOF_PKT, 50);
        exp_eof(16'd0);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL empty_eof_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL empty_eof%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        logic stall;
        logic [7:0] held;
        int stalls;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        tx_ready = 1'b0;
        send_rec(9'h012, 9'h1F0, 9'h0AB, 9'h100, 1'b0);
        stall  = 1'b0;
        held   = 8'h00;
        stalls = 0;
        for (int c = 0; c < 300 && got_q.size() < REC_PKT; c++) begin
            tx_ready = pat[c % 4];
            @(negedge clk);
            if (stall) begin
                stalls++;
                checks++; if (tx_valid !== 1'b1 || tx_data !== held) begin
                    errors++; $display("FAIL bp_hold got valid %b data %02h exp 1 %02h", tx_valid, tx_data, held); end
            end
            stall = tx_valid && !tx_ready;
            held  = tx_data;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        checks++; if (stalls == 0) begin errors++; $display("FAIL bp_stalls got 0 exp >0"); end
        exp_q = '{8'hA5, 8'h00, 8'h12, 8'h01, 8'hF0, 8'h00, 8'hAB, 8'h01, 8'h00};
`ifdef FEATURE_TX_CHECKSUM_EN
        exp_q.push_back(8'h49);
`endif
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0;
        // Park the FSM on a stalled EOF so no record leaves the FIFO during the burst.
        pulse_fe();
        step();
        step();
        for (int i = 0; i < 20; i++) send_rec(9'(i), 9'(i + 100), 9'(2 * i), 9'(3 * i + 1), 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
        tx_ready = 1'b1;
        wait_bytes(EOF_PKT, 50);
        pulse_fe();
        wait_bytes(2 * EOF_PKT + 16 * REC_PKT, 1000);
        exp_eof(16'd0);
        for (int i = 0; i < 16; i++) exp_rec(9'(i), 9'(i + 100), 9'(2 * i), 9'(3 * i + 1));
        exp_eof(16'h0010);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovf_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_ordering();
        do_reset();
        tx_ready = 1'b1;
        send_rec(9'd1, 9'd2, 9'd3, 9'd4, 1'b0);
        send_rec(9'd20, 9'd40, 9'd60, 9'd80, 1'b0);
        pulse_fe();
        wait_bytes(2 * REC_PKT + EOF_PKT, 200);
        send_rec(9'd100, 9'd200, 9'd0, 9'd511, 1'b0);
        send_rec(9'd7, 9'd7, 9'd9, 9'd9, 1'b1);
        wait_bytes(4 * REC_PKT + 2 * EOF_PKT, 400);
        exp_rec(9'd1, 9'd2, 9'd3, 9'd4);
        exp_rec(9'd20, 9'd40, 9'd60, 9'd80);
        exp_eof(16'd2);
        exp_rec(9'd100, 9'd200, 9'd0, 9'd511);
        exp_rec(9'd7, 9'd7, 9'd9, 9'd9);
        exp_eof(16'd2);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL order_len got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL order_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        tx_ready = 1'b1;
        send_rec(9'd3, 9'd10, 9'd5, 9'd300, 1'b0);
        repeat (4) step();
        n   = got_q.size();
        rst = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", tx_valid); end
        rst = 1'b0;
        repeat (20) step();
        checks++; if (got_q.size() != n) begin
            errors++; $display("FAIL rstmid_resume got %0d bytes exp %0d", got_q.size(), n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_box();
        test_backpressure();
        test_overflow();
        test_ordering();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
